// File: rtl/fft_output_sequencer.sv
// fft_output_sequencer
// Emits 2^ADDR_W consecutive output-buffer indices per accepted frame request,
// in natural or bit-reversed order. It honours downstream back-pressure, queues
// up to PEND_MAX requests, and chains frames back-to-back without a bubble.
// Optional build macro FFT_OSEQ_STATS_EN adds a 16-bit completed-frame counter.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         frame request pulse (one request per high cycle)
//   bitrev_mode   index order, latched at frame launch (1 = bit-reversed)
//   out_ready     downstream accepts the current index
//   addr_o        output index (count or bit-reversed count)
//   count_o       raw sample position within the frame
//   valid_o       addr_o/count_o valid (same as busy_o)
//   sof_o, eof_o  first / last sample of the frame
//   busy_o        sequencer is running a frame
//   pend_o        queued, not yet launched requests
//   overflow_o    sticky flag: a request was dropped
//   frame_cnt_o   (FFT_OSEQ_STATS_EN only) frames completed, wraps at 16 bits
module fft_output_sequencer #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bitrev_mode,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              valid_o,
    output logic              sof_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              overflow_o
`ifdef FFT_OSEQ_STATS_EN
    ,
    output logic [15:0]       frame_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] LAST     = '1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] count;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_next;
    logic              mode;
    logic              overflow;

    logic run;
    logic accept;
    logic at_last;
    logic frame_end;
    logic pend_nz;
    logic launch;
    logic from_pend;
    logic direct;
    logic queue_start;
    logic drop;
    logic [ADDR_W-1:0] rev_count;

    // Control decode from registered state and current inputs
    assign run       = (state == RUN);
    assign accept    = run & out_ready;
    assign at_last   = (count == LAST);
    assign frame_end = accept & at_last;
    assign pend_nz   = (pending != '0);
    assign launch    = (~run & (start | pend_nz)) | (frame_end & (start | pend_nz));
    // Queued requests launch first; a start only launches directly when nothing is queued
    assign from_pend   = launch & pend_nz;
    assign direct      = launch & ~pend_nz;
    assign queue_start = start & ~direct;
    assign drop        = queue_start & (pending == PEND_MAX) & ~from_pend;

    // Pending counter: +1 for a queued start, -1 for a consumed request
    always_comb begin
        pending_next = pending;
        if (queue_start && !drop && !from_pend)
            pending_next = pending + PEND_W'(1);
        else if (from_pend && !queue_start)
            pending_next = pending - PEND_W'(1);
    end

    // Sequencer state, sample counter, latched order and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            pending  <= '0;
            mode     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (drop)
                overflow <= 1'b1;
            if (launch) begin
                state <= RUN;
                count <= '0;
                mode  <= bitrev_mode;
            end else if (frame_end) begin
                state <= IDLE;
                count <= '0;
            end else if (accept) begin
                count <= count + ADDR_W'(1);
            end
        end
    end

    // Bit i of the count moves to position ADDR_W-1-i
    always_comb begin
        rev_count = '0;
        for (int unsigned i = 0; i < ADDR_W; i++)
            rev_count[ADDR_W-1-i] = count[i];
    end

    assign addr_o     = mode ? rev_count : count;
    assign count_o    = count;
    assign valid_o    = run;
    assign busy_o     = run;
    assign sof_o      = run & (count == '0);
    assign eof_o      = run & at_last;
    assign pend_o     = pending;
    assign overflow_o = overflow;

`ifdef FFT_OSEQ_STATS_EN
    logic [15:0] frame_cnt;

    // Counts accepted end-of-frame samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_end)
            frame_cnt <= frame_cnt + 16'(1);
    end

    assign frame_cnt_o = frame_cnt;
`endif

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Scoreboard bench for fft_output_sequencer (ADDR_W=6, PEND_W=2).
// Stimulus pushes each expected frame into a queue; a negedge monitor pops and
// compares on every accepted output. Directed checks cover latency, ordering,
// back-pressure, queueing, overflow and asynchronous reset.
module tb_fft_output_sequencer;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned N      = 64;

    logic              clk;
    logic              rst;
    logic              start;
    logic              bitrev_mode;
    logic              out_ready;
    logic [ADDR_W-1:0] addr_o;
    logic [ADDR_W-1:0] count_o;
    logic              valid_o;
    logic              sof_o;
    logic              eof_o;
    logic              busy_o;
    logic [PEND_W-1:0] pend_o;
    logic              overflow_o;
`ifdef FFT_OSEQ_STATS_EN
    logic [15:0]       frame_cnt_o;
`endif

    fft_output_sequencer #(.ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bitrev_mode (bitrev_mode),
        .out_ready   (out_ready),
        .addr_o      (addr_o),
        .count_o     (count_o),
        .valid_o     (valid_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .busy_o      (busy_o),
        .pend_o      (pend_o),
        .overflow_o  (overflow_o)
`ifdef FFT_OSEQ_STATS_EN
        ,
        .frame_cnt_o (frame_cnt_o)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] cnt;
        logic              sof;
        logic              eof;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vcnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rev6(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        r = {<<{x}};
        return r;
    endfunction

    task automatic push_frame(input logic m);
        exp_t e;
        for (int i = 0; i < int'(N); i++) begin
            e.cnt  = ADDR_W'(i);
            e.addr = m ? rev6(ADDR_W'(i)) : ADDR_W'(i);
            e.sof  = (i == 0);
            e.eof  = (i == int'(N) - 1);
            q.push_back(e);
        end
    endtask

    // Scoreboard monitor: one pop per accepted output; queue flushed on reset
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (valid_o) vcnt++;
            if (valid_o && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_addr", int'(addr_o), int'(e.addr));
                    chk("sb_count", int'(count_o), int'(e.cnt));
                    chk("sb_sof", int'(sof_o), int'(e.sof));
                    chk("sb_eof", int'(eof_o), int'(e.eof));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_count(input int target);
        int n = 0;
        while (int'(count_o) != target && n < 300) begin
            tick();
            n++;
        end
        chk("reach_count", int'(count_o), target);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 600) begin
            tick();
            n++;
        end
        chk("idle_reached", int'(busy_o), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_sof"}, int'(sof_o), 0);
        chk({tag, "_eof"}, int'(eof_o), 0);
        chk({tag, "_addr"}, int'(addr_o), 0);
        chk({tag, "_count"}, int'(count_o), 0);
        chk({tag, "_pend"}, int'(pend_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
    endtask

    initial begin
        int v0;
        int exp_br[6];
        exp_br = '{0, 32, 16, 48, 8, 40};

        rst = 1'b1;
        start = 1'b0;
        bitrev_mode = 1'b0;
        out_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Natural order, single frame, one-cycle launch latency
        v0 = vcnt;
        push_frame(1'b0);
        pulse_start();
        chk("latency_valid", int'(valid_o), 1);
        chk("latency_count", int'(count_o), 0);
        chk("latency_sof", int'(sof_o), 1);
        wait_idle();
        chk("nat_frame_len", vcnt - v0, 64);
        chk("nat_pend_end", int'(pend_o), 0);

        // Bit-reversed order; mode flip mid-frame must be ignored
        bitrev_mode = 1'b1;
        push_frame(1'b1);
        pulse_start();
        for (int j = 0; j < 6; j++) begin
            chk("bitrev_seq", int'(addr_o), exp_br[j]);
            if (j == 2) bitrev_mode = 1'b0;
            tick();
        end
        run_to_count(63);
        chk("bitrev_last_addr", int'(addr_o), 63);
        chk("bitrev_last_eof", int'(eof_o), 1);
        wait_idle();

        // Queued second request: back-to-back frames
        v0 = vcnt;
        push_frame(1'b0);
        push_frame(1'b0);
        pulse_start();
        run_to_count(20);
        pulse_start();
        chk("b2b_pend_queued", int'(pend_o), 1);
        run_to_count(63);
        chk("b2b_pend_at_eof", int'(pend_o), 1);
        chk("b2b_eof", int'(eof_o), 1);
        tick();
        chk("b2b_next_valid", int'(valid_o), 1);
        chk("b2b_next_sof", int'(sof_o), 1);
        chk("b2b_next_count", int'(count_o), 0);
        chk("b2b_pend_drained", int'(pend_o), 0);
        wait_idle();
        chk("b2b_total_valid", vcnt - v0, 128);

        // Back-pressure: five stalled cycles at count 10
        v0 = vcnt;
        push_frame(1'b0);
        pulse_start();
        run_to_count(10);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("stall_addr_hold", int'(addr_o), 10);
            chk("stall_valid", int'(valid_o), 1);
        end
        out_ready = 1'b1;
        wait_idle();
        chk("stall_frame_len", vcnt - v0, 69);

        // Overflow: one launching start plus four more, queue holds three
        v0 = vcnt;
        for (int f = 0; f < 4; f++) push_frame(1'b0);
        pulse_start();
        start = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        start = 1'b0;
        chk("ovf_pend_sat", int'(pend_o), 3);
        chk("ovf_flag", int'(overflow_o), 1);
        wait_idle();
        chk("ovf_total_valid", vcnt - v0, 256);
        chk("ovf_sticky", int'(overflow_o), 1);
        chk("ovf_pend_end", int'(pend_o), 0);

        // Asynchronous reset mid-frame, then a clean restart
        push_frame(1'b0);
        pulse_start();
        run_to_count(30);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        push_frame(1'b0);
        pulse_start();
        chk("restart_count", int'(count_o), 0);
        chk("restart_sof", int'(sof_o), 1);
        wait_idle();
`ifdef FFT_OSEQ_STATS_EN
        chk("frame_cnt", int'(frame_cnt_o), 1);
`endif
        tick();
        chk("sb_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
